// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants and state type for the seven-segment scan controller
package ssd_pkg;

  // All segments off on an active-low display
  localparam logic [6:0] SSD_BLANK  = 7'b1111111;
  localparam int         NIBBLE_W   = 4;
  localparam int         DEC_DATA_W = 5;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;

  // Digit index width; a single display still needs a one-bit index
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// rtl/ssd_scan_ctrl_if.sv - valid/ready interface carrying a packed hex value into the scan controller
interface ssd_scan_ctrl_if #(
  parameter int NUM_DIGITS = 6
);
  import ssd_pkg::*;

  logic                           in_valid;
  logic                           in_ready;
  logic [NIBBLE_W*NUM_DIGITS-1:0] in_value;

  modport master (output in_valid, output in_value, input in_ready);
  modport slave  (input in_valid, input in_value, output in_ready);

endinterface

// File: rtl/ssd_scan_ctrl_lzb_mask.sv
// rtl/ssd_scan_ctrl_lzb_mask.sv - leading-zero blank mask (module ssd_lzb_mask), built only with SSD_LZB_EN
`ifdef SSD_LZB_EN
module ssd_lzb_mask
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] shadow,
  output logic [NUM_DIGITS-1:0]          blank
);

  logic upper_zero;

  // Walk from the most significant digit down; a digit blanks while every digit above it is zero
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (shadow[NIBBLE_W*k +: NIBBLE_W] == '0);
      blank[k]   = (k != 0) && upper_zero;
    end
  end

endmodule
`endif

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - scans one shared seven-segment decoder across NUM_DIGITS displays (SSD_LZB_EN adds leading-zero blanking)
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  ssd_scan_ctrl_if.slave          in_if,
  output logic                    dec_en,
  output logic [DEC_DATA_W-1:0]   dec_data,
  input  logic [6:0]              dec_ssd,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scan_state_t                    state;
  logic [IDX_W-1:0]               idx;
  logic [NIBBLE_W*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]          blank;
  logic                           in_ready_q;
  logic [NIBBLE_W*NUM_DIGITS-1:0] shadow_sh;
  logic [NUM_DIGITS-1:0]          blank_sh;

  assign in_if.in_ready = in_ready_q;

`ifdef SSD_LZB_EN
  ssd_lzb_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lzb_mask (
    .shadow (shadow),
    .blank  (blank)
  );
`else
  assign blank = '0;
`endif

  // Present the current digit to the decoder only while scanning; shifts keep selects in range for any NUM_DIGITS
  always_comb begin
    shadow_sh = shadow >> (NIBBLE_W * idx);
    blank_sh  = blank >> idx;
    dec_en    = 1'b0;
    dec_data  = '0;
    if (state == SCAN) begin
      dec_en   = !blank_sh[0];
      dec_data = {1'b0, shadow_sh[NIBBLE_W-1:0]};
    end
  end

  // Sequencer: accept into shadow, capture one decoded digit per cycle, pulse done, return to idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      shadow     <= '0;
      hex_out    <= {NUM_DIGITS{SSD_BLANK}};
      in_ready_q <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_if.in_valid && in_ready_q) begin
            shadow     <= in_if.in_value;
            idx        <= '0;
            state      <= SCAN;
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SCAN: begin
          hex_out[7*idx +: 7] <= dec_ssd;
          if (idx == LAST_IDX) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          idx        <= '0;
          done       <= 1'b0;
          busy       <= 1'b0;
          in_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
